// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, registered syncs, bright, frame strobe/count.
// Optional VGA_TEST_PATTERN_EN adds a registered eight-bar colour pattern on test_rgb.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned V_VIS     = 480,
    parameter int unsigned V_FP      = 10,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_tick,
    output logic       frame_start,
`ifdef VGA_TEST_PATTERN_EN
    output logic [7:0]  frame_cnt,
    output logic [11:0] test_rgb
`else
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_VISIBLE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_N = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_N = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_VIS - 1);

    logic [DW-1:0] r_div_cnt;
    logic          w_adv;
    logic          w_frame_wrap;
    logic [9:0]    w_h_next;
    logic [9:0]    w_v_next;
    logic          w_bright_next;

    // Syncs and bright are decoded from the next counts so they align with hCount/vCount.
    always_comb begin
        w_adv        = (r_div_cnt == DIV_LAST);
        w_frame_wrap = w_adv && (hCount == H_LAST) && (vCount == V_LAST);
        w_h_next     = hCount;
        w_v_next     = vCount;
        if (w_adv) begin
            if (hCount == H_LAST) begin
                w_h_next = '0;
                w_v_next = (vCount == V_LAST) ? '0 : vCount + 10'd1;
            end else begin
                w_h_next = hCount + 10'd1;
            end
        end
        w_bright_next = (w_h_next >= H_VIS_LO) && (w_h_next <= H_VIS_HI) &&
                        (w_v_next >= V_VIS_LO) && (w_v_next <= V_VIS_HI);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div_cnt   <= '0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= SYNC_POL;
            vSync       <= SYNC_POL;
            bright      <= 1'b0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            r_div_cnt   <= w_adv ? '0 : r_div_cnt + DW'(1);
            hCount      <= w_h_next;
            vCount      <= w_v_next;
            hSync       <= (w_h_next < H_SYNC_N) ? SYNC_POL : ~SYNC_POL;
            vSync       <= (w_v_next < V_SYNC_N) ? SYNC_POL : ~SYNC_POL;
            bright      <= w_bright_next;
            pix_tick    <= w_adv;
            frame_start <= w_frame_wrap;
            if (w_frame_wrap) frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W   = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
    localparam logic [9:0]  BAR_W_N = 10'(BAR_W);

    logic [9:0]  w_bar_idx;
    logic [11:0] w_rgb_next;

    always_comb begin
        w_bar_idx  = (w_h_next - H_VIS_LO) / BAR_W_N;
        w_rgb_next = 12'h000;
        if (w_bright_next) begin
            case (w_bar_idx)
                10'd0:   w_rgb_next = 12'hFFF;
                10'd1:   w_rgb_next = 12'hFF0;
                10'd2:   w_rgb_next = 12'h0FF;
                10'd3:   w_rgb_next = 12'h0F0;
                10'd4:   w_rgb_next = 12'hF0F;
                10'd5:   w_rgb_next = 12'hF00;
                10'd6:   w_rgb_next = 12'h00F;
                default: w_rgb_next = 12'h000;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) test_rgb <= '0;
        else       test_rgb <= w_rgb_next;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-geometry table plus two small-geometry instances
// checked every cycle against an arithmetic raster model (pixel index = edges / CLK_DIV).
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        br;
        logic        tick;
        logic        fs;
        logic [7:0]  fc;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int unsigned d, hs, hbp, hv, hfp, vs, vbp, vv, vfp;
        bit          pol;
    } geo_t;

    typedef struct {
        int unsigned t;
        obs_t        exp;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic [9:0] hD, vD, hA, vA, hB, vB;
    logic hsD, vsD, brD, tkD, fsD, hsA, vsA, brA, tkA, fsA, hsB, vsB, brB, tkB, fsB;
    logic [7:0] fcD, fcA, fcB;
    logic [11:0] rgbD, rgbA, rgbB;

    vga_timing_gen u_dflt (
        .Clk(Clk), .Reset(Reset), .hCount(hD), .vCount(vD), .hSync(hsD), .vSync(vsD),
        .bright(brD), .pix_tick(tkD), .frame_start(fsD),
`ifdef VGA_TEST_PATTERN_EN
        .frame_cnt(fcD), .test_rgb(rgbD)
`else
        .frame_cnt(fcD)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(1), .H_VISIBLE(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_VIS(4), .V_FP(1), .SYNC_POL(1'b1)
    ) u_a (
        .Clk(Clk), .Reset(Reset), .hCount(hA), .vCount(vA), .hSync(hsA), .vSync(vsA),
        .bright(brA), .pix_tick(tkA), .frame_start(fsA),
`ifdef VGA_TEST_PATTERN_EN
        .frame_cnt(fcA), .test_rgb(rgbA)
`else
        .frame_cnt(fcA)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_VISIBLE(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_VIS(4), .V_FP(1), .SYNC_POL(1'b0)
    ) u_b (
        .Clk(Clk), .Reset(Reset), .hCount(hB), .vCount(vB), .hSync(hsB), .vSync(vsB),
        .bright(brB), .pix_tick(tkB), .frame_start(fsB),
`ifdef VGA_TEST_PATTERN_EN
        .frame_cnt(fcB), .test_rgb(rgbB)
`else
        .frame_cnt(fcB)
`endif
    );

`ifndef VGA_TEST_PATTERN_EN
    assign rgbD = '0;
    assign rgbA = '0;
    assign rgbB = '0;
`endif

    obs_t oD, oA, oB;
    assign oD = {hD, vD, hsD, vsD, brD, tkD, fsD, fcD, rgbD};
    assign oA = {hA, vA, hsA, vsA, brA, tkA, fsA, fcA, rgbA};
    assign oB = {hB, vB, hsB, vsB, brB, tkB, fsB, fcB, rgbB};

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned t = 0;
    geo_t GD, GA, GB;
    vec_t tab[10];

    function automatic logic [11:0] bar_colour(input int unsigned idx);
        case (idx)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Raster state after t clock edges since reset release.
    function automatic obs_t model(input int unsigned tt, input geo_t g);
        obs_t o;
        int unsigned ht, vt, p, fr, h, v;
        ht = g.hs + g.hbp + g.hv + g.hfp;
        vt = g.vs + g.vbp + g.vv + g.vfp;
        fr = ht * vt;
        p  = tt / g.d;
        h  = p % ht;
        v  = (p / ht) % vt;
        o.h    = 10'(h);
        o.v    = 10'(v);
        o.hs   = (h < g.hs) ? g.pol : !g.pol;
        o.vs   = (v < g.vs) ? g.pol : !g.pol;
        o.br   = (h >= g.hs + g.hbp) && (h < g.hs + g.hbp + g.hv) &&
                 (v >= g.vs + g.vbp) && (v < g.vs + g.vbp + g.vv);
        o.tick = (tt >= g.d) && (tt % g.d == 0);
        o.fs   = o.tick && (p % fr == 0);
        o.fc   = 8'((p / fr) % 256);
        o.rgb  = '0;
`ifdef VGA_TEST_PATTERN_EN
        if (o.br) o.rgb = bar_colour((h - (g.hs + g.hbp)) / (g.hv / 8));
`endif
        return o;
    endfunction

    function automatic obs_t mk(input int unsigned h, input int unsigned v, input bit hs,
                                input bit vs, input bit br, input bit tick);
        obs_t o;
        o = '0;
        o.h = 10'(h); o.v = 10'(v); o.hs = hs; o.vs = vs; o.br = br; o.tick = tick;
        return o;
    endfunction

    task automatic chk(input string tag, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b br=%b tk=%b fs=%b fc=%0d rgb=%h want h=%0d v=%0d hs=%b vs=%b br=%b tk=%b fs=%b fc=%0d rgb=%h",
                     tag, t, act.h, act.v, act.hs, act.vs, act.br, act.tick, act.fs, act.fc, act.rgb,
                     exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.tick, exp.fs, exp.fc, exp.rgb);
        end
    endtask

    task automatic step_small();
        @(posedge Clk);
        @(negedge Clk);
        t++;
        chk("small_a", oA, model(t, GA));
        chk("small_b", oB, model(t, GB));
    endtask

    task automatic check_reset_all(input string tag);
        chk({tag, "_d"}, oD, model(0, GD));
        chk({tag, "_a"}, oA, model(0, GA));
        chk({tag, "_b"}, oB, model(0, GB));
    endtask

    initial begin
        int unsigned k;
        GD = '{d:4, hs:96, hbp:48, hv:640, hfp:16, vs:2, vbp:33, vv:480, vfp:10, pol:1'b0};
        GA = '{d:2, hs:2, hbp:1, hv:8, hfp:1, vs:1, vbp:1, vv:4, vfp:1, pol:1'b1};
        GB = '{d:1, hs:2, hbp:1, hv:8, hfp:1, vs:1, vbp:1, vv:4, vfp:1, pol:1'b0};

        // Default geometry (800x525, div 4, active-low syncs), expected values from the timing table.
        tab[0] = '{3,    mk(0,   0, 0, 0, 0, 0)};
        tab[1] = '{4,    mk(1,   0, 0, 0, 0, 1)};
        tab[2] = '{5,    mk(1,   0, 0, 0, 0, 0)};
        tab[3] = '{380,  mk(95,  0, 0, 0, 0, 1)};
        tab[4] = '{384,  mk(96,  0, 1, 0, 0, 1)};
        tab[5] = '{576,  mk(144, 0, 1, 0, 0, 1)};
        tab[6] = '{3196, mk(799, 0, 1, 0, 0, 1)};
        tab[7] = '{3200, mk(0,   1, 0, 0, 0, 1)};
        tab[8] = '{6400, mk(0,   2, 0, 1, 0, 1)};
        tab[9] = '{6408, mk(2,   2, 0, 1, 0, 1)};

        repeat (2) @(negedge Clk);
        check_reset_all("in_reset");
        Reset = 1'b0;
        t = 0;
        k = 0;
        chk("released_d", oD, model(0, GD));
        for (int unsigned c = 0; c < 6408; c++) begin
            step_small();
            if (k < 10 && tab[k].t == t) begin
                chk($sformatf("dflt_vec%0d", k), oD, tab[k].exp);
                k++;
            end
        end

        // Random-length runs interrupted by asynchronous resets landing mid-cycle.
        for (int unsigned ep = 0; ep < 6; ep++) begin
            int unsigned run, hold;
            run  = $urandom_range(1, 400);
            hold = $urandom_range(1, 3);
            for (int unsigned c = 0; c < run; c++) step_small();
            @(posedge Clk);
            #2 Reset = 1'b1;
            #1 check_reset_all("async_reset");
            for (int unsigned c = 0; c < hold; c++) begin
                @(negedge Clk);
                check_reset_all("reset_hold");
            end
            Reset = 1'b0;
            t = 0;
        end

        // 257 full frames of the small raster: frame_cnt wraps 255 -> 0 on both instances.
        @(posedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        t = 0;
        for (int unsigned c = 0; c < 168 * 257 + 4; c++) step_small();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
